// File: rtl/rr_reg_arb_pkg.sv
// Shared types and width helpers for the round-robin register arbiter.
// Optional feature macro (used by rr_reg_arbiter): ARB_PRIORITY0_EN.
package rr_reg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Pointer width is $clog2(n), kept at least 1 bit.
    function automatic int ptr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Hold counter covers 0..h-1, kept at least 1 bit so h=0 still elaborates.
    function automatic int hold_w(input int h);
        return (h < 1) ? 1 : $clog2(h + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after i_ptr, wrapping.
module rr_pick
    import rr_reg_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_winner,
    output logic               o_any
);

    int w_idx;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k >= NUM_REQ) ? int'(i_ptr) + k - NUM_REQ : int'(i_ptr) + k;
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_winner       = PTR_W'(w_idx);
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin write arbiter in front of a shared holding register, with a post-write hold gap.
// Define ARB_PRIORITY0_EN to make requester 0 strict-high-priority.
module rr_reg_arbiter
    import rr_reg_arb_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  DATA_W      = 4,
    parameter int  HOLD_CYCLES = 2,
    localparam int PTR_W       = ptr_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         reg_q,
    output logic [PTR_W-1:0]          reg_owner,
    output logic                      reg_wr_pulse,
    output logic                      busy
);

    localparam int                HOLD_W    = hold_w(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [DATA_W-1:0]   r_q;
    logic [PTR_W-1:0]    r_owner;
    logic                r_pulse;

    logic [NUM_REQ-1:0]  w_pick_grant;
    logic [PTR_W-1:0]    w_pick_winner;
    logic                w_pick_any;
    logic [NUM_REQ-1:0]  w_grant;
    logic [PTR_W-1:0]    w_winner;
    logic                w_any;
    logic                w_prio;
    logic                w_xfer;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic [DATA_W-1:0]   w_win_data;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_grant  (w_pick_grant),
        .o_winner (w_pick_winner),
        .o_any    (w_pick_any)
    );

    // Winner selection; the optional override pre-empts the round-robin pick for requester 0.
    always_comb begin
        w_grant  = w_pick_grant;
        w_winner = w_pick_winner;
        w_any    = w_pick_any;
        w_prio   = 1'b0;
`ifdef ARB_PRIORITY0_EN
        if (req_valid[0]) begin
            w_grant  = {{(NUM_REQ-1){1'b0}}, 1'b1};
            w_winner = '0;
            w_any    = 1'b1;
            w_prio   = 1'b1;
        end else begin
            w_prio   = 1'b0;
        end
`endif
    end

    // Mux the winning requester's data word out of the packed bus.
    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_data = req_data[i*DATA_W +: DATA_W];
            end else begin
                w_win_data = w_win_data;
            end
        end
    end

    assign w_xfer    = (r_state == IDLE) && w_any;
    assign w_ptr_nxt = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
    assign req_ready = (r_state == IDLE) ? w_grant : '0;

    // FSM state and hold counter registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next-state logic: a write opens a HOLD window that counts down to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (w_xfer && (HOLD_CYCLES > 0)) begin
                    w_state_nxt = HOLD;
                    w_hold_nxt  = HOLD_INIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_hold_nxt  = r_hold_cnt - HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Shared register, owner, write strobe and rotation pointer.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_q      <= '0;
            r_owner  <= '0;
            r_pulse  <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            r_pulse <= w_xfer;
            if (w_xfer) begin
                r_q      <= w_win_data;
                r_owner  <= w_winner;
                r_rr_ptr <= w_prio ? r_rr_ptr : w_ptr_nxt;
            end else begin
                r_q      <= r_q;
                r_owner  <= r_owner;
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

    assign reg_q        = r_q;
    assign reg_owner    = r_owner;
    assign reg_wr_pulse = r_pulse;
    assign busy         = (r_state == HOLD);

endmodule
